axi4lite_rr_arbiter: RTL

AXI4LITE_RR_ARBITER -- requirements
Module: axi4lite_rr_arbiter

---
 rtl/axi4lite_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_rr_arbiter.sv
// ============================================================================
//  Module      : axi4lite_rr_arbiter
//  Description : Two-requester AXI4-Lite round-robin arbiter onto a single
//                downstream master port. Write and read paths are arbitrated
//                independently, each with its own FSM and fairness pointer.
//                Optional response timeout with drain states is built when
//                the macro AXI4LITE_ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_rr_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    // Requester side (index 0 in the LSBs)
    input  logic [2*ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [5:0]                  s_axi_awprot,
    input  logic [1:0]                  s_axi_awvalid,
    output logic [1:0]                  s_axi_awready,
    input  logic [2*DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0] s_axi_wstrb,
    input  logic [1:0]                  s_axi_wvalid,
    output logic [1:0]                  s_axi_wready,
    output logic [3:0]                  s_axi_bresp,
    output logic [1:0]                  s_axi_bvalid,
    input  logic [1:0]                  s_axi_bready,
    input  logic [2*ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [5:0]                  s_axi_arprot,
    input  logic [1:0]                  s_axi_arvalid,
    output logic [1:0]                  s_axi_arready,
    output logic [2*DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [3:0]                  s_axi_rresp,
    output logic [1:0]                  s_axi_rvalid,
    input  logic [1:0]                  s_axi_rready,
    // Shared downstream master
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    // Path ownership
    output logic [1:0]                  wr_grant_o,
    output logic [1:0]                  rd_grant_o
);

    localparam int         c_STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] c_SLVERR     = 2'b10;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_ADDR  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ADDR  = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
    localparam logic [1:0] W_DRAIN = 2'd3;
    localparam logic [1:0] R_DRAIN = 2'd3;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
`endif

    // Elaboration-time guard on the timeout range
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_err
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    // Route a single-bit value onto the lane of the selected requester
    function automatic logic [1:0] f_lane(input logic idx, input logic v);
        return idx ? {v, 1'b0} : {1'b0, v};
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [1:0] r_wr_state, w_wr_state_nxt;
    logic [1:0] r_wr_grant;
    logic       r_wr_ptr;          // requester favoured when both request
    logic       r_aw_done, r_w_done;
    logic       w_wr_idx, w_wr_pick;
    logic       w_aw_done_nxt, w_w_done_nxt;
    logic       w_wr_to;
    logic       w_aw_rdy, w_w_rdy, w_b_vld;
    logic [1:0] w_b_resp;

    assign w_wr_idx      = r_wr_grant[1];
    assign w_wr_pick     = (&s_axi_awvalid) ? r_wr_ptr : s_axi_awvalid[1];
    assign w_aw_done_nxt = r_aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_w_done_nxt  = r_w_done  | (m_axi_wvalid  & m_axi_wready);
    assign wr_grant_o    = r_wr_grant;

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    logic [15:0] r_wr_cnt;
    assign w_wr_to = (r_wr_state == W_RESP) && (r_wr_cnt == c_TIMEOUT);

    // Count cycles waiting for the write response, saturating at the limit
    always_ff @(posedge aclk) begin
        if (!aresetn)                  r_wr_cnt <= '0;
        else if (r_wr_state != W_RESP) r_wr_cnt <= '0;
        else if (r_wr_cnt != c_TIMEOUT) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
`else
    assign w_wr_to = 1'b0;
`endif

    // Write FSM state register
    always_ff @(posedge aclk) begin
        if (!aresetn) r_wr_state <= W_IDLE;
        else          r_wr_state <= w_wr_state_nxt;
    end

    // Write grant, fairness pointer and per-channel completion flags
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_grant <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            if (r_wr_state == W_IDLE && w_wr_state_nxt == W_ADDR) begin
                r_wr_grant <= f_lane(w_wr_pick, 1'b1);
                r_wr_ptr   <= ~w_wr_pick;
            end else if (w_wr_state_nxt == W_IDLE) begin
                r_wr_grant <= 2'b00;
            end
            if (r_wr_state == W_ADDR && w_wr_state_nxt == W_ADDR) begin
                r_aw_done <= w_aw_done_nxt;
                r_w_done  <= w_w_done_nxt;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    // Write FSM next-state logic
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE: if (|s_axi_awvalid) w_wr_state_nxt = W_ADDR;
            W_ADDR: if (w_aw_done_nxt && w_w_done_nxt) w_wr_state_nxt = W_RESP;
            W_RESP: begin
                if (w_wr_to) begin
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                    if (s_axi_bready[w_wr_idx]) w_wr_state_nxt = W_DRAIN;
`endif
                end else if (m_axi_bvalid && s_axi_bready[w_wr_idx]) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            W_DRAIN: if (m_axi_bvalid) w_wr_state_nxt = W_IDLE;
`endif
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: steer the granted requester onto the master port
    always_comb begin
        m_axi_awaddr  = w_wr_idx ? s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_awaddr[ADDR_WIDTH-1:0];
        m_axi_awprot  = w_wr_idx ? s_axi_awprot[5:3] : s_axi_awprot[2:0];
        m_axi_wdata   = w_wr_idx ? s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_axi_wdata[DATA_WIDTH-1:0];
        m_axi_wstrb   = w_wr_idx ? s_axi_wstrb[2*c_STRB_WIDTH-1:c_STRB_WIDTH] : s_axi_wstrb[c_STRB_WIDTH-1:0];
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        w_aw_rdy      = 1'b0;
        w_w_rdy       = 1'b0;
        w_b_vld       = 1'b0;
        w_b_resp      = 2'b00;
        case (r_wr_state)
            W_ADDR: begin
                m_axi_awvalid = s_axi_awvalid[w_wr_idx] & ~r_aw_done;
                w_aw_rdy      = m_axi_awready & ~r_aw_done;
                m_axi_wvalid  = s_axi_wvalid[w_wr_idx] & ~r_w_done;
                w_w_rdy       = m_axi_wready & ~r_w_done;
            end
            W_RESP: begin
                if (w_wr_to) begin
                    w_b_vld  = 1'b1;
                    w_b_resp = c_SLVERR;
                end else begin
                    w_b_vld      = m_axi_bvalid;
                    w_b_resp     = m_axi_bresp;
                    m_axi_bready = s_axi_bready[w_wr_idx];
                end
            end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            W_DRAIN: m_axi_bready = 1'b1;
`endif
            default: ;
        endcase
    end

    assign s_axi_awready = f_lane(w_wr_idx, w_aw_rdy);
    assign s_axi_wready  = f_lane(w_wr_idx, w_w_rdy);
    assign s_axi_bvalid  = f_lane(w_wr_idx, w_b_vld);
    assign s_axi_bresp   = w_wr_idx ? {w_b_resp, 2'b00} : {2'b00, w_b_resp};

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [1:0]            r_rd_state, w_rd_state_nxt;
    logic [1:0]            r_rd_grant;
    logic                  r_rd_ptr;
    logic                  w_rd_idx, w_rd_pick;
    logic                  w_rd_to;
    logic                  w_ar_rdy, w_r_vld;
    logic [1:0]            w_r_resp;
    logic [DATA_WIDTH-1:0] w_r_data;

    assign w_rd_idx   = r_rd_grant[1];
    assign w_rd_pick  = (&s_axi_arvalid) ? r_rd_ptr : s_axi_arvalid[1];
    assign rd_grant_o = r_rd_grant;

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    logic [15:0] r_rd_cnt;
    assign w_rd_to = (r_rd_state == R_DATA) && (r_rd_cnt == c_TIMEOUT);

    // Count cycles waiting for read data, saturating at the limit
    always_ff @(posedge aclk) begin
        if (!aresetn)                   r_rd_cnt <= '0;
        else if (r_rd_state != R_DATA)  r_rd_cnt <= '0;
        else if (r_rd_cnt != c_TIMEOUT) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
`else
    assign w_rd_to = 1'b0;
`endif

    // Read FSM state register
    always_ff @(posedge aclk) begin
        if (!aresetn) r_rd_state <= R_IDLE;
        else          r_rd_state <= w_rd_state_nxt;
    end

    // Read grant and fairness pointer
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_grant <= 2'b00;
            r_rd_ptr   <= 1'b0;
        end else if (r_rd_state == R_IDLE && w_rd_state_nxt == R_ADDR) begin
            r_rd_grant <= f_lane(w_rd_pick, 1'b1);
            r_rd_ptr   <= ~w_rd_pick;
        end else if (w_rd_state_nxt == R_IDLE) begin
            r_rd_grant <= 2'b00;
        end
    end

    // Read FSM next-state logic
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE: if (|s_axi_arvalid) w_rd_state_nxt = R_ADDR;
            R_ADDR: if (m_axi_arvalid && m_axi_arready) w_rd_state_nxt = R_DATA;
            R_DATA: begin
                if (w_rd_to) begin
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                    if (s_axi_rready[w_rd_idx]) w_rd_state_nxt = R_DRAIN;
`endif
                end else if (m_axi_rvalid && s_axi_rready[w_rd_idx]) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            R_DRAIN: if (m_axi_rvalid) w_rd_state_nxt = R_IDLE;
`endif
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs: steer the granted requester onto the master port
    always_comb begin
        m_axi_araddr  = w_rd_idx ? s_axi_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_araddr[ADDR_WIDTH-1:0];
        m_axi_arprot  = w_rd_idx ? s_axi_arprot[5:3] : s_axi_arprot[2:0];
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        w_ar_rdy      = 1'b0;
        w_r_vld       = 1'b0;
        w_r_resp      = 2'b00;
        w_r_data      = '0;
        case (r_rd_state)
            R_ADDR: begin
                m_axi_arvalid = s_axi_arvalid[w_rd_idx];
                w_ar_rdy      = m_axi_arready;
            end
            R_DATA: begin
                if (w_rd_to) begin
                    w_r_vld  = 1'b1;
                    w_r_resp = c_SLVERR;
                end else begin
                    w_r_vld      = m_axi_rvalid;
                    w_r_resp     = m_axi_rresp;
                    w_r_data     = m_axi_rdata;
                    m_axi_rready = s_axi_rready[w_rd_idx];
                end
            end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            R_DRAIN: m_axi_rready = 1'b1;
`endif
            default: ;
        endcase
    end

    assign s_axi_arready = f_lane(w_rd_idx, w_ar_rdy);
    assign s_axi_rvalid  = f_lane(w_rd_idx, w_r_vld);
    assign s_axi_rresp   = w_rd_idx ? {w_r_resp, 2'b00} : {2'b00, w_r_resp};
    assign s_axi_rdata   = w_rd_idx ? {w_r_data, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, w_r_data};

endmodule

`default_nettype wire
